// File: rtl/sccb_write_arbiter.sv
// sccb_write_arbiter: shares one SCCB transmitter between two register-write requesters,
// sequencing start, busy/done tracking, inter-write gap, soft-reset settle and hang detection.
module sccb_write_arbiter #(
    parameter int CLK_FREQUENCY     = 25000000,
    parameter int ROUND_ROBIN       = 0,
    parameter int GAP_CYCLES        = 250,
    parameter int RESET_WAIT_CYCLES = CLK_FREQUENCY / 1000,
    parameter int BUSY_TIMEOUT      = 16,
    parameter int DONE_TIMEOUT      = CLK_FREQUENCY / 1000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_address,
    input  logic [7:0] i_req0_data,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_address,
    input  logic [7:0] i_req1_data,
    output logic       o_req1_ready,
    output logic       o_SCCB_start,
    output logic [7:0] o_SCCB_address,
    output logic [7:0] o_SCCB_data,
    input  logic       i_SCCB_ready,
    output logic       o_busy,
    output logic       o_grant,
    output logic       o_error,
    output logic [7:0] o_error_address,
    input  logic       i_error_clear
);
    localparam int MAX_AB  = RESET_WAIT_CYCLES > DONE_TIMEOUT ? RESET_WAIT_CYCLES : DONE_TIMEOUT;
    localparam int MAX_CD  = GAP_CYCLES > BUSY_TIMEOUT ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int MAX_CNT = MAX_AB > MAX_CD ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    addr_q, addr_d, data_q, data_d, err_addr_q, err_addr_d;
    logic          grant_q, grant_d, favor_q, favor_d, long_q, long_d;
    logic          error_q, error_d, rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic          start_q, start_d, busy_q, busy_d;
    logic          pick, timeout;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        grant_d    = grant_q;
        favor_d    = favor_q;
        long_d     = long_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        rdy0_d     = 1'b0;
        rdy1_d     = 1'b0;
        start_d    = 1'b0;
        timeout    = 1'b0;
        pick = (ROUND_ROBIN != 0 && i_req0_valid && i_req1_valid) ? favor_q : !i_req0_valid;
        case (state_q)
            IDLE: if (i_SCCB_ready && (i_req0_valid || i_req1_valid)) begin
                state_d = ISSUE;
                grant_d = pick;
                favor_d = !pick;
                addr_d  = pick ? i_req1_address : i_req0_address;
                data_d  = pick ? i_req1_data : i_req0_data;
                rdy0_d  = !pick;
                rdy1_d  = pick;
            end
            ISSUE: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (!i_SCCB_ready) begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) timeout = 1'b1;
            else cnt_d = cnt_q + 1'b1;
            WAIT_DONE: if (i_SCCB_ready) begin
                state_d = GAP;
                cnt_d   = '0;
                long_d  = addr_q == 8'h12 && data_q[7];
            end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) timeout = 1'b1;
            else cnt_d = cnt_q + 1'b1;
            GAP: if (cnt_q == (long_q ? CW'(RESET_WAIT_CYCLES - 1) : CW'(GAP_CYCLES - 1))) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        // a timeout outranks a simultaneous clear so no hang goes unreported
        if (timeout) begin
            state_d = GAP;
            cnt_d   = '0;
            long_d  = 1'b0;
            error_d = 1'b1;
            if (!error_q) err_addr_d = addr_q;
        end else if (i_error_clear) begin
            error_d    = 1'b0;
            err_addr_d = '0;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            grant_q    <= 1'b0;
            favor_q    <= 1'b0;
            long_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            rdy0_q     <= 1'b0;
            rdy1_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            favor_q    <= favor_d;
            long_q     <= long_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            rdy0_q     <= rdy0_d;
            rdy1_q     <= rdy1_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign o_req0_ready    = rdy0_q;
    assign o_req1_ready    = rdy1_q;
    assign o_SCCB_start    = start_q;
    assign o_SCCB_address  = addr_q;
    assign o_SCCB_data     = data_q;
    assign o_busy          = busy_q;
    assign o_grant         = grant_q;
    assign o_error         = error_q;
    assign o_error_address = err_addr_q;
endmodule

// File: doc/sccb_write_arbiter.md
Name: sccb_write_arbiter

Overview:
- Shares the single SCCB transmitter between two register-write requesters:
  - port 0: the boot-time camera configuration sequencer.
  - port 1: runtime tuning logic (exposure/gain/white-balance writes).
- Sequences each write: issue start, track transmitter busy/ready, enforce inter-write gap and post-soft-reset settle time, detect a hung transmitter.
- Sits between the requesters and sccb_transmitter; drives its start/address/data and observes its ready.

Parameters:
- CLK_FREQUENCY, 25000000, system clock in Hz.
- ROUND_ROBIN, 0, 0 = fixed priority to port 0; 1 = alternate grant when both request.
- GAP_CYCLES, 250, idle cycles enforced after every completed write (min 1).
- RESET_WAIT_CYCLES, CLK_FREQUENCY/1000, settle cycles after a COM7 soft-reset write (replaces GAP_CYCLES).
- BUSY_TIMEOUT, 16, max cycles from start pulse until transmitter ready falls.
- DONE_TIMEOUT, CLK_FREQUENCY/1000, max cycles with ready low before a write is declared hung.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req0_valid  in  1  port 0 write request; held with address/data until o_req0_ready.
- i_req0_address  in  8  port 0 register address.
- i_req0_data  in  8  port 0 register data.
- o_req0_ready  out  1  one-cycle accept pulse for port 0.
- i_req1_valid, i_req1_address, i_req1_data, o_req1_ready: same as port 0, for port 1.
- o_SCCB_start  out  1  one-cycle start pulse to transmitter.
- o_SCCB_address  out  8  latched register address.
- o_SCCB_data  out  8  latched register data.
- i_SCCB_ready  in  1  transmitter idle (level).
- o_busy  out  1  high in any state other than IDLE.
- o_grant  out  1  port owning the current/last write.
- o_error  out  1  sticky timeout flag.
- o_error_address  out  8  address of the first timed-out write since last clear.
- i_error_clear  in  1  clears o_error.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0. State IDLE. Round-robin pointer favours port 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Accepts only when i_SCCB_ready=1.
  - Fixed priority: port 0 wins whenever valid.
  - Round robin: when both are valid, grant the port not granted last; a single requester is always granted.
  - On grant: pulse the matching o_reqN_ready for one cycle, latch address/data into o_SCCB_*, set o_grant, go to ISSUE.
  - The other port's ready stays 0.
- ISSUE: o_SCCB_start=1 for exactly this cycle; counter cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - i_SCCB_ready=0 -> WAIT_DONE, counter cleared.
  - Counter reaching BUSY_TIMEOUT -> timeout.
- WAIT_DONE:
  - i_SCCB_ready=1 -> GAP.
  - Counter reaching DONE_TIMEOUT -> timeout.
- GAP:
  - Counts GAP_CYCLES, or RESET_WAIT_CYCLES if the latched address==0x12 and data[7]=1; then -> IDLE.
  - Requests arriving during GAP wait; valid must be held.
- Timeout: o_error<=1; o_error_address<=latched address only if o_error was 0; go directly to GAP using GAP_CYCLES.
- i_error_clear: clears o_error and o_error_address; a timeout in the same cycle wins (flag stays 1).
- Latency: accept pulse to o_SCCB_start is 1 cycle. Completion to next accept is gap+1 cycles minimum.
- o_SCCB_address/data: stable from the accept cycle until the next accept.
- Counter width: $clog2 of max(RESET_WAIT_CYCLES, DONE_TIMEOUT, GAP_CYCLES, BUSY_TIMEOUT)+1; no wrap possible.
- Valid dropped before ready (protocol violation): request is simply not seen.
- Reset mid-write: arbiter returns to IDLE immediately. Transmitter reset is the parent's responsibility.

Test Plan:
- Bench overrides: GAP_CYCLES=4, RESET_WAIT_CYCLES=20, BUSY_TIMEOUT=8, DONE_TIMEOUT=50.
- Single write: port 0 writes 0x3A/0x04; transmitter model drops ready 2 cycles after start and holds it low 30 cycles -> one o_req0_ready pulse, start 1 cycle later with address 0x3A and data 0x04, next accept no earlier than 5 cycles after ready rises.
- Contention: both valid continuously, ROUND_ROBIN=0 -> only port 0 granted until it drops valid. With ROUND_ROBIN=1 -> grants alternate 0,1,0,1; o_grant matches.
- Soft reset: port 0 writes 0x12/0x80 -> GAP lasts 20 cycles. A 0x12/0x00 write -> GAP lasts 4 cycles.
- Hung transmitter:
  - Ready never falls after start -> o_error=1, o_error_address=0x3A after 8 cycles; arbiter accepts the next request.
  - A second timeout on 0x40 keeps address 0x3A.
  - i_error_clear asserted in the same cycle as a timeout -> o_error stays 1.
- Async reset asserted during WAIT_DONE -> all outputs 0 without a clock edge. After release, a pending port 1 request is accepted normally.
